press_counter: RTL and testbench
================================

PRESS_COUNTER -- requirements
Module: press_counter

Interface
REQ-001 Parameter MODULUS, default 4, count modulus; SHALL be >= 2; count runs 0..MODULUS-1.
REQ-002 Parameter EDGE_SEL, default EDGE_FALL, selects the counted trigger edge (EDGE_FALL or EDGE_RISE).
REQ-003 Parameter DEB_CYCLES, default 16, number of stable clk cycles the debounce requires; range 2..65535.
REQ-004 Localparam CW = max(1, clog2(MODULUS)), width of count_o.
REQ-005 clk  in  1  system clock, rising-edge active.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 trig_i  in  1  raw trigger (button); asynchronous to clk.
REQ-008 en_i  in  1  count enable; detected edges are discarded while low.
REQ-009 dir_i  in  1  0 = count up, 1 = count down.
REQ-010 clear_i  in  1  synchronous clear of count and flags.
REQ-011 count_o  out  CW  current count.
REQ-012 wrap_o  out  1  one-cycle pulse on the cycle count wraps.
REQ-013 flag_o  out  1  level; set on wrap, held until the next counted event or clear.

Function
REQ-014 trig_i SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 One "event" SHALL be one selected edge of the conditioned trigger; at most one event per clk cycle.
REQ-016 Without debounce, count_o SHALL update on the 3rd rising clk edge after the one that first samples the new trig_i level.
REQ-017 Up, event, count < MODULUS-1: count+1, flag_o<=0, wrap_o=0.
REQ-018 Up, event, count == MODULUS-1: count<=0, flag_o<=1, wrap_o pulses 1 cycle.
REQ-019 Down, event, count > 0: count-1, flag_o<=0, wrap_o=0.
REQ-020 Down, event, count == 0: count<=MODULUS-1, flag_o<=1, wrap_o pulses 1 cycle.
REQ-021 Event with en_i=0 SHALL be dropped, not deferred; count, flag_o, wrap_o unchanged (wrap_o=0).
REQ-022 clear_i=1 SHALL force count 0, flag_o 0, wrap_o 0 on the next edge, taking priority over a simultaneous event.
REQ-023 dir_i SHALL be sampled in the same cycle as the event; dir_i changes without an event have no effect.
REQ-024 Arithmetic SHALL never yield count >= MODULUS, including non-power-of-2 MODULUS.
REQ-025 wrap_o SHALL never be high for 2 consecutive cycles.

Reset
REQ-026 rst=1 SHALL immediately force count_o=0, flag_o=0, wrap_o=0, clear synchronizer and edge-history flops to the idle level (1 for EDGE_FALL, 0 for EDGE_RISE), and reset the debounce counter.
REQ-027 After rst deasserts, no spurious event SHALL be generated from a trig_i already at the idle level.
REQ-028 rst asserted mid-debounce or mid-pulse SHALL abort it; no event emitted.

Configuration
REQ-029 Macro PRESS_COUNTER_DEBOUNCE_EN defined: the synchronized trigger SHALL be accepted as a new level only after DEB_CYCLES consecutive identical samples; event latency becomes 3+DEB_CYCLES clk cycles.
REQ-030 Macro undefined: no debounce logic compiled; latency per REQ-016; DEB_CYCLES ignored.

Structure
REQ-031 Package press_counter_pkg SHALL hold the edge-select typedef (EDGE_FALL, EDGE_RISE), default MODULUS and DEB_CYCLES constants.
REQ-032 Sub-module trig_conditioner SHALL contain synchronizer, optional debounce and edge detector, emitting a one-cycle event strobe; press_counter holds count/flag logic.

Verification
REQ-033 MODULUS=4, up, en=1: 4 falling edges -> count 1,2,3,0; wrap_o one pulse on 4th; flag_o=1 until 5th edge, then count=1, flag_o=0.
REQ-034 MODULUS=5, down from reset: 1 edge -> count=4, wrap_o pulse, flag_o=1; 4 more -> 3,2,1,0, no wrap.
REQ-035 clear_i high same cycle as event strobe at count=3 -> count=0, flag_o=0, wrap_o=0.
REQ-036 en_i=0 during 3 edges then en_i=1 -> count unchanged; next edge increments by exactly 1.
REQ-037 PRESS_COUNTER_DEBOUNCE_EN, DEB_CYCLES=8: glitch of 5 cycles -> no event; clean 20-cycle low -> one event, count updates 11 cycles after first sample.
REQ-038 rst pulsed asynchronously mid-count (count=2, flag_o=1) -> outputs 0 within rst assertion, no event on release with trig_i idle.

Source files
------------

// File: rtl/press_counter_pkg.sv
// Shared types and defaults for the press counter: trigger edge selection,
// default modulus/debounce length and the count-width helper.
package press_counter_pkg;

   typedef enum logic {
      EDGE_FALL = 1'b0,
      EDGE_RISE = 1'b1
   } edge_sel_t;

   localparam int DEF_MODULUS    = 4;
   localparam int DEF_DEB_CYCLES = 16;

   // Count width: max(1, clog2(m)).
   function automatic int cnt_width(input int m);
      return (m > 2) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/press_counter_if.sv
// Control/status bundle of the press counter: trigger and controls in,
// count, wrap pulse and wrap flag out.
interface press_counter_if #(
   parameter int CW = 2
);
   logic          trig_i;
   logic          en_i;
   logic          dir_i;
   logic          clear_i;
   logic [CW-1:0] count_o;
   logic          wrap_o;
   logic          flag_o;

   modport master (
      output trig_i, en_i, dir_i, clear_i,
      input  count_o, wrap_o, flag_o
   );

   modport slave (
      input  trig_i, en_i, dir_i, clear_i,
      output count_o, wrap_o, flag_o
   );
endinterface

// File: rtl/press_counter_trig_conditioner.sv
// Trigger conditioning: 2-flop synchronizer, optional debounce (build macro
// PRESS_COUNTER_DEBOUNCE_EN) and a registered one-cycle edge strobe.
module trig_conditioner
   import press_counter_pkg::*;
#(
   parameter edge_sel_t EDGE_SEL   = EDGE_FALL,
   parameter int        DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   output logic evt
);

   localparam logic IDLE = (EDGE_SEL == EDGE_FALL);

   if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
      $error("trig_conditioner: DEB_CYCLES out of range 2..65535");
   end

   logic [1:0] sync_reg;
   logic       cond;
   logic       hist_reg;
   logic       evt_reg;
   logic       strobe_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_reg <= {2{IDLE}};
      else     sync_reg <= {sync_reg[0], trig};
   end

`ifdef PRESS_COUNTER_DEBOUNCE_EN
   localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

   logic        level_reg, level_next;
   logic [15:0] deb_cnt_reg, deb_cnt_next;

   // The accepted level only moves after DEB_CYCLES consecutive differing samples.
   always_comb begin
      level_next   = level_reg;
      deb_cnt_next = deb_cnt_reg;
      if (sync_reg[1] == level_reg) begin
         deb_cnt_next = '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
         level_next   = sync_reg[1];
         deb_cnt_next = '0;
      end else begin
         deb_cnt_next = deb_cnt_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_reg   <= IDLE;
         deb_cnt_reg <= '0;
      end else begin
         level_reg   <= level_next;
         deb_cnt_reg <= deb_cnt_next;
      end
   end

   assign cond = level_reg;
`else
   assign cond = sync_reg[1];
`endif

   assign strobe_next = (EDGE_SEL == EDGE_FALL) ? (hist_reg & ~cond) : (~hist_reg & cond);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_reg <= IDLE;
         evt_reg  <= 1'b0;
      end else begin
         hist_reg <= cond;
         evt_reg  <= strobe_next;
      end
   end

   assign evt = evt_reg;

endmodule

// File: rtl/press_counter.sv
// Modulo up/down press counter with wrap pulse and sticky wrap flag.
// Debounce is compiled in only when PRESS_COUNTER_DEBOUNCE_EN is defined.
module press_counter
   import press_counter_pkg::*;
#(
   parameter int        MODULUS    = DEF_MODULUS,
   parameter edge_sel_t EDGE_SEL   = EDGE_FALL,
   parameter int        DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   press_counter_if.slave  bus
);

   localparam int            CW        = cnt_width(MODULUS);
   localparam logic [CW-1:0] MAX_COUNT = CW'(MODULUS - 1);

   if (MODULUS < 2) begin : g_bad_modulus
      $error("press_counter: MODULUS must be >= 2");
   end

   logic          evt;
   logic [CW-1:0] count_reg, count_next;
   logic          flag_reg, flag_next;
   logic          wrap_reg, wrap_next;

   trig_conditioner #(
      .EDGE_SEL   (EDGE_SEL),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_cond (
      .clk  (clk),
      .rst  (rst),
      .trig (bus.trig_i),
      .evt  (evt)
   );

   // Wrap is compared against the explicit terminal value so non-power-of-2
   // moduli never leave the legal range.
   always_comb begin
      count_next = count_reg;
      flag_next  = flag_reg;
      wrap_next  = 1'b0;
      if (bus.clear_i) begin
         count_next = '0;
         flag_next  = 1'b0;
      end else if (evt && bus.en_i) begin
         if (!bus.dir_i) begin
            if (count_reg == MAX_COUNT) begin
               count_next = '0;
               flag_next  = 1'b1;
               wrap_next  = 1'b1;
            end else begin
               count_next = count_reg + CW'(1);
               flag_next  = 1'b0;
            end
         end else begin
            if (count_reg == '0) begin
               count_next = MAX_COUNT;
               flag_next  = 1'b1;
               wrap_next  = 1'b1;
            end else begin
               count_next = count_reg - CW'(1);
               flag_next  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
         flag_reg  <= 1'b0;
         wrap_reg  <= 1'b0;
      end else begin
         count_reg <= count_next;
         flag_reg  <= flag_next;
         wrap_reg  <= wrap_next;
      end
   end

   assign bus.count_o = count_reg;
   assign bus.flag_o  = flag_reg;
   assign bus.wrap_o  = wrap_reg;

endmodule

// File: tb/tb_press_counter.sv
// Bench for press_counter: a MODULUS=4 falling-edge unit and a MODULUS=5
// rising-edge unit driven with complementary triggers, checked against an arithmetic model.
module tb_press_counter;
   import press_counter_pkg::*;

   localparam int DEB = 8;
`ifdef PRESS_COUNTER_DEBOUNCE_EN
   localparam int LAT = 3 + DEB;
`else
   localparam int LAT = 3;
`endif
   localparam int MA  = 4;
   localparam int MB  = 5;
   localparam int CWA = cnt_width(MA);
   localparam int CWB = cnt_width(MB);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   press_counter_if #(.CW(CWA)) if_a ();
   press_counter_if #(.CW(CWB)) if_b ();

   press_counter #(.MODULUS(MA), .EDGE_SEL(EDGE_FALL), .DEB_CYCLES(DEB)) dut_a (
      .clk (clk), .rst (rst), .bus (if_a.slave)
   );
   press_counter #(.MODULUS(MB), .EDGE_SEL(EDGE_RISE), .DEB_CYCLES(DEB)) dut_b (
      .clk (clk), .rst (rst), .bus (if_b.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int ca = 0, fa = 0, cb = 0, fb = 0;
   int wraps_a = 0, wraps_b = 0, dbl = 0;
   bit prev_a = 0, prev_b = 0;

   always @(negedge clk) begin
      if (if_a.wrap_o === 1'b1) begin
         wraps_a++;
         if (prev_a) dbl++;
      end
      if (if_b.wrap_o === 1'b1) begin
         wraps_b++;
         if (prev_b) dbl++;
      end
      prev_a = (if_a.wrap_o === 1'b1);
      prev_b = (if_b.wrap_o === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Model of one counted press: step by +/-1 modulo m, wrap when leaving 0..m-1.
   function automatic void apply(input int m, input bit en, input bit dir, input bit clr,
                                 inout int c, inout int f, output int w);
      int nc;
      w = 0;
      if (clr) begin
         c = 0;
         f = 0;
      end else if (en) begin
         nc = c + (dir ? -1 : 1);
         w  = (nc < 0 || nc >= m) ? 1 : 0;
         c  = (nc + m) % m;
         f  = w;
      end
   endfunction

   task automatic set_ctrl(input bit en, input bit dir);
      if_a.en_i  = en;  if_b.en_i  = en;
      if_a.dir_i = dir; if_b.dir_i = dir;
   endtask

   task automatic press(input bit en, input bit dir, input bit clr);
      int wa, wb;
      wraps_a = 0; wraps_b = 0;
      set_ctrl(en, dir);
      if_a.trig_i = 1'b0; if_b.trig_i = 1'b1;
      repeat (LAT) @(posedge clk);
      #1;
      chk("early_a", if_a.count_o, ca);
      chk("early_b", if_b.count_o, cb);
      if (clr) begin
         if_a.clear_i = 1'b1; if_b.clear_i = 1'b1;
      end
      @(posedge clk);
      #1;
      if_a.clear_i = 1'b0; if_b.clear_i = 1'b0;
      apply(MA, en, dir, clr, ca, fa, wa);
      apply(MB, en, dir, clr, cb, fb, wb);
      $display("press en=%0b dir=%0b clr=%0b : a=%0d/%0d b=%0d/%0d (model %0d/%0d %0d/%0d)",
               en, dir, clr, if_a.count_o, if_a.flag_o, if_b.count_o, if_b.flag_o, ca, fa, cb, fb);
      chk("count_a", if_a.count_o, ca);
      chk("flag_a",  if_a.flag_o,  fa);
      chk("count_b", if_b.count_o, cb);
      chk("flag_b",  if_b.flag_o,  fb);
      repeat (2) @(posedge clk);
      #1;
      chk("wrap_a", wraps_a, wa);
      chk("wrap_b", wraps_b, wb);
      // Release half: no event, and a dir change alone must not matter.
      set_ctrl(1'b1, 1'($urandom_range(0, 1)));
      if_a.trig_i = 1'b1; if_b.trig_i = 1'b0;
      repeat (LAT + 2) @(posedge clk);
      #1;
      chk("hold_a", if_a.count_o, ca);
      chk("hold_b", if_b.count_o, cb);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_count_a"}, if_a.count_o, 0);
      chk({tag, "_flag_a"},  if_a.flag_o,  0);
      chk({tag, "_wrap_a"},  if_a.wrap_o,  0);
      chk({tag, "_count_b"}, if_b.count_o, 0);
      chk({tag, "_flag_b"},  if_b.flag_o,  0);
      chk({tag, "_wrap_b"},  if_b.wrap_o,  0);
   endtask

   initial begin
      if_a.trig_i = 1'b1; if_b.trig_i = 1'b0;
      if_a.clear_i = 1'b0; if_b.clear_i = 1'b0;
      set_ctrl(1'b1, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      check_zero("post_reset_idle");

      // Five up presses: A 1,2,3,0(wrap),1 ; B 1,2,3,4,0(wrap).
      for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b1);
      // Five down presses from zero: both wrap on the first.
      for (int i = 0; i < 5; i++) press(1'b1, 1'b1, 1'b0);
      // Disabled presses are dropped, not deferred.
      for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b0);
      // Clear coinciding with the event strobe at count 3.
      for (int i = 0; i < 8 && ca != 3; i++) press(1'b1, 1'b0, 1'b0);
      press(1'b1, 1'b0, 1'b1);

      for (int i = 0; i < 30; i++)
         press(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

`ifdef PRESS_COUNTER_DEBOUNCE_EN
      if_a.trig_i = 1'b0; if_b.trig_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      if_a.trig_i = 1'b1; if_b.trig_i = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      chk("glitch_a", if_a.count_o, ca);
      chk("glitch_b", if_b.count_o, cb);
`endif

      for (int i = 0; i < 10 && (ca == 0 || cb == 0); i++) press(1'b1, 1'b0, 1'b0);
      // Asynchronous reset in the middle of a press, trigger back to idle before release.
      wraps_a = 0; wraps_b = 0;
      if_a.trig_i = 1'b0; if_b.trig_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_rst");
      if_a.trig_i = 1'b1; if_b.trig_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ca = 0; fa = 0; cb = 0; fb = 0;
      repeat (LAT + 3) @(posedge clk);
      #1;
      check_zero("after_rst");
      chk("after_rst_wraps", wraps_a + wraps_b, 0);
      press(1'b1, 1'b0, 1'b0);

      chk("wrap_back_to_back", dbl, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
